miniled_scan_shifter: RTL
=========================

Name: miniled_scan_shifter

Overview:
Parametrised serial shift engine for daisy-chained constant-current MiniLED driver chips. It is the generalised successor of the fixed 4-scan/16-bit shift path, with configurable chips per chain, channels, scan lines, DCLK divider and LE/blanking widths, and it adds global brightness scaling and frame-start queuing. Each frame it reads zone grey levels from a synchronous frame RAM, scales them, shifts them out MSB-first on SDI/DCLK, latches with LE and drives the one-hot scan lines. It sits between the zone-brightness RAM writer and the LED board pins.

Parameters:
CHIPS, 4, driver chips per chain
CH, 16, channels per chip
SCAN, 4, scan lines (multiplex ratio)
GRAY_W, 16, grey-level width
CLK_DIV, 2, I_clk cycles per DCLK half-period (>=1)
LE_W, 4, LE high width in I_clk cycles (>=1)
DEAD, 8, blanking cycles after LE with all scans off (>=1)
GCLK_DIV, 1, I_clk cycles per GCLK half-period
ADDR_W, clog2(SCAN*CHIPS*CH), RAM address width

Ports:
I_clk  in  1  system clock
I_rst_n  in  1  asynchronous active-low reset
I_frame_start  in  1  one-cycle pulse: new frame available in RAM
I_bright  in  8  global brightness, sampled when a frame starts
O_rd_en  out  1  RAM read strobe
O_rd_addr  out  ADDR_W  RAM word address
I_rd_data  in  GRAY_W  RAM data, valid exactly 1 cycle after O_rd_en
O_busy  out  1  frame in progress
O_frame_done  out  1  one-cycle pulse after the last line's blanking ends
DCLK  out  1  shift clock to chips
SDI  out  1  serial data to chips
LE  out  1  latch enable
GCLK  out  1  greyscale PWM clock
O_scan  out  SCAN  one-hot, active-high scan drive

Behaviour:
- Clock and reset: one clock, I_clk. Reset is asynchronous, active-low, on I_rst_n.
- Reset values: all outputs 0. FSM in IDLE. Pending flag, line and word counters cleared. bright_q = 255.
- WPL = CHIPS*CH words per line. The word for line s, slot k is at address s*WPL + k.
- Shift order within a line: k = WPL-1 down to 0, each word MSB first, so slot 0 lands in the chip nearest SDI.
- Scaling: shift_word = (I_rd_data * (bright_q+1)) >> 8, keeping the low GRAY_W bits.
  - bright_q = 255 gives identity.
  - bright_q = 0 gives I_rd_data >> 8.
- FSM states: IDLE, FETCH, CAPT, SHIFT, LATCH, BLANK.
  - IDLE: on I_frame_start, latch bright_q, set line = 0 and k = WPL-1, go to FETCH. O_busy = 1 from the next cycle.
  - FETCH (1 cycle): O_rd_en = 1 and O_rd_addr = line*WPL + k. O_rd_en is 0 in every other state.
  - CAPT (1 cycle): load the scaled word into the shift register, bit counter = GRAY_W-1, go to SHIFT.
  - SHIFT: each bit lasts 2*CLK_DIV cycles. SDI is set at the start of the bit with DCLK low. DCLK goes high for the second CLK_DIV cycles, so chips sample on the DCLK rising edge.
    - After bit 0: if k > 0, decrement k and go to FETCH.
    - Otherwise go to LATCH.
    - DCLK stays low outside SHIFT.
  - LATCH: LE = 1 for LE_W cycles while DCLK = 0 and SDI holds its last value. O_scan clears to 0 on the first LATCH cycle.
  - BLANK: DEAD cycles with O_scan = 0 and GCLK held low.
    - At exit, O_scan = onehot(line). This is held through the shifting of the next line until its LATCH.
    - If line < SCAN-1: line++, k = WPL-1, go to FETCH.
    - Else: pulse O_frame_done, then go to IDLE, or go straight to FETCH with line 0 if the pending flag is set (clearing it, re-sampling I_bright). O_busy drops only when entering IDLE.
  - After the last line, O_scan keeps onehot(SCAN-1) until the next frame's first LATCH.
- I_frame_start while busy: sets a one-deep pending flag. Further pulses while pending are dropped. It never aborts the current frame.
- I_frame_start coinciding with the O_frame_done cycle: treated as pending, so the next frame starts with no IDLE cycle.
- GCLK: free-running toggle every GCLK_DIV cycles in every state except BLANK, where it is forced low and its divider is cleared.
- Reset mid-frame: all outputs go to 0 immediately (asynchronously). After release, the block waits in IDLE for a new I_frame_start.
- Line time in I_clk cycles: WPL*(2 + 2*CLK_DIV*GRAY_W) + LE_W + DEAD.

Test Plan:
- Pixel order and line time. Setup: CHIPS=1, CH=2, SCAN=2, CLK_DIV=1, LE_W=2, DEAD=3, bright=255; RAM[0..3] = 16'hA5F0, 16'h0001, 16'h8000, 16'hFFFF. Required:
  - Line 0 SDI bit stream is 0x0001 then 0xA5F0, MSB first, sampled on DCLK rising edges.
  - Line 1 stream is 0xFFFF then 0x8000.
  - Exactly 32 DCLK rises per line.
  - Line length is 2*(2+32)+5 = 73 cycles.
- Brightness scaling. bright=127 with a word of 16'hFFFF shifts 16'h7FFF. bright=0 with 16'h1234 shifts 16'h0012.
- Scan and LE sequencing:
  - LE is high for exactly 2 cycles after the last DCLK fall, with DCLK = 0 throughout.
  - O_scan = 0 during LE and the 3 DEAD cycles, then 2'b01 after line 0 and 2'b10 after line 1.
  - O_frame_done pulses once.
  - GCLK is low during BLANK.
- Frame queuing. Send 3 I_frame_start pulses mid-frame. Required: exactly one extra frame runs back-to-back, O_busy never drops between the two frames, and O_frame_done pulses twice in total.
- Read handshake. In every cycle where O_rd_en is high, O_rd_addr = line*WPL + k. O_rd_en is never high outside FETCH. The total count of O_rd_en pulses per frame equals SCAN*WPL = 4.
- Reset mid-SHIFT. Assert I_rst_n low mid-SHIFT. Required: DCLK, SDI, LE, GCLK and O_scan go to 0 immediately. After release there is no activity until I_frame_start, then line 0 restarts from k = WPL-1.

Source files
------------

// File: rtl/miniled_scan_shifter.sv
// Serial shift engine for daisy-chained constant-current MiniLED drivers.
// Each frame it reads zone grey levels from a synchronous RAM and scales them by a
// global brightness. It shifts them MSB-first on SDI/DCLK, latches with LE, blanks
// all scans, then drives the one-hot scan line of the line just latched.
module miniled_scan_shifter #(
    parameter int CHIPS    = 4,
    parameter int CH       = 16,
    parameter int SCAN     = 4,
    parameter int GRAY_W   = 16,
    parameter int CLK_DIV  = 2,
    parameter int LE_W     = 4,
    parameter int DEAD     = 8,
    parameter int GCLK_DIV = 1,
    parameter int ADDR_W   = $clog2(SCAN * CHIPS * CH)
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_frame_start,
    input  logic [7:0]        I_bright,
    output logic              O_rd_en,
    output logic [ADDR_W-1:0] O_rd_addr,
    input  logic [GRAY_W-1:0] I_rd_data,
    output logic              O_busy,
    output logic              O_frame_done,
    output logic              DCLK,
    output logic              SDI,
    output logic              LE,
    output logic              GCLK,
    output logic [SCAN-1:0]   O_scan
);

    localparam int WPL     = CHIPS * CH;
    localparam int LINE_W  = (SCAN > 1) ? $clog2(SCAN) : 1;
    localparam int K_W     = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int BIT_W   = (GRAY_W > 1) ? $clog2(GRAY_W) : 1;
    localparam int DIV_W   = (CLK_DIV > 0) ? $clog2(2 * CLK_DIV) : 1;
    localparam int CNT_MAX = (LE_W > DEAD) ? LE_W : DEAD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int GDIV_W  = (GCLK_DIV > 1) ? $clog2(GCLK_DIV) : 1;

    localparam logic [K_W-1:0]    K_LAST    = K_W'(WPL - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(SCAN - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(GRAY_W - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  LE_LAST   = CNT_W'(LE_W - 1);
    localparam logic [CNT_W-1:0]  DEAD_LAST = CNT_W'(DEAD - 1);
    localparam logic [GDIV_W-1:0] GDIV_LAST = GDIV_W'(GCLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_CAPT  = 3'd2,
        S_SHIFT = 3'd3,
        S_LATCH = 3'd4,
        S_BLANK = 3'd5
    } state_t;

    // RAM word address of slot k on a given scan line.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [LINE_W-1:0] line,
                                                  input logic [K_W-1:0]    k);
        return ADDR_W'(line) * ADDR_W'(WPL) + ADDR_W'(k);
    endfunction

    // Brightness scaling: (data * (bright + 1)) >> 8, so 255 is identity.
    function automatic logic [GRAY_W-1:0] scale(input logic [GRAY_W-1:0] data,
                                                input logic [7:0]        bright);
        logic [GRAY_W+8:0] prod;
        prod = {9'd0, data} * {{GRAY_W{1'b0}}, ({1'b0, bright} + 9'd1)};
        return GRAY_W'(prod >> 8);
    endfunction

    state_t              state_q;
    logic [LINE_W-1:0]   line_q;
    logic [K_W-1:0]      k_q;
    logic [BIT_W-1:0]    bit_q;
    logic [DIV_W-1:0]    div_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [GRAY_W-1:0]   sh_q;
    logic [7:0]          bright_q;
    logic                pend_q;
    logic                rd_en_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                busy_q;
    logic                done_q;
    logic                dclk_q;
    logic                sdi_q;
    logic                le_q;
    logic [SCAN-1:0]     scan_q;
    logic                gclk_q;
    logic [GDIV_W-1:0]   gdiv_q;
    logic [GRAY_W-1:0]   scaled_d;
    logic                blank_next_d;

    assign scaled_d = scale(I_rd_data, bright_q);

    // Flags cycles whose successor is a BLANK cycle, so GCLK can be registered low there.
    always_comb begin
        blank_next_d = 1'b0;
        if ((state_q == S_LATCH) && (cnt_q == LE_LAST)) begin
            blank_next_d = 1'b1;
        end else if ((state_q == S_BLANK) && (cnt_q != DEAD_LAST)) begin
            blank_next_d = 1'b1;
        end else begin
            blank_next_d = 1'b0;
        end
    end

    // Frame sequencer: word fetch, bit-serial shift, latch, blanking and scan drive.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q   <= S_IDLE;
            line_q    <= {LINE_W{1'b0}};
            k_q       <= {K_W{1'b0}};
            bit_q     <= {BIT_W{1'b0}};
            div_q     <= {DIV_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            sh_q      <= {GRAY_W{1'b0}};
            bright_q  <= 8'hFF;
            pend_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= {ADDR_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dclk_q    <= 1'b0;
            sdi_q     <= 1'b0;
            le_q      <= 1'b0;
            scan_q    <= {SCAN{1'b0}};
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            // A start request during a frame is remembered once and never aborts it.
            if (I_frame_start && (state_q != S_IDLE)) begin
                pend_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (I_frame_start) begin
                        bright_q  <= I_bright;
                        line_q    <= {LINE_W{1'b0}};
                        k_q       <= K_LAST;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= addr_of({LINE_W{1'b0}}, K_LAST);
                        busy_q    <= 1'b1;
                        state_q   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_q <= S_CAPT;
                end
                S_CAPT: begin
                    sh_q    <= scaled_d;
                    sdi_q   <= scaled_d[GRAY_W-1];
                    bit_q   <= BIT_LAST;
                    div_q   <= {DIV_W{1'b0}};
                    dclk_q  <= 1'b0;
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_q  <= {DIV_W{1'b0}};
                        dclk_q <= 1'b0;
                        if (bit_q != {BIT_W{1'b0}}) begin
                            bit_q <= bit_q - BIT_W'(1);
                            sh_q  <= {sh_q[GRAY_W-2:0], 1'b0};
                            sdi_q <= sh_q[GRAY_W-2];
                        end else if (k_q != {K_W{1'b0}}) begin
                            k_q       <= k_q - K_W'(1);
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= addr_of(line_q, k_q - K_W'(1));
                            state_q   <= S_FETCH;
                        end else begin
                            le_q    <= 1'b1;
                            scan_q  <= {SCAN{1'b0}};
                            cnt_q   <= {CNT_W{1'b0}};
                            state_q <= S_LATCH;
                        end
                    end else begin
                        div_q  <= div_q + DIV_W'(1);
                        dclk_q <= ((div_q + DIV_W'(1)) >= DIV_W'(CLK_DIV));
                    end
                end
                S_LATCH: begin
                    if (cnt_q == LE_LAST) begin
                        le_q    <= 1'b0;
                        cnt_q   <= {CNT_W{1'b0}};
                        state_q <= S_BLANK;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_BLANK: begin
                    if (cnt_q == DEAD_LAST) begin
                        cnt_q  <= {CNT_W{1'b0}};
                        scan_q <= SCAN'(1'b1) << line_q;
                        if (line_q != LINE_LAST) begin
                            line_q    <= line_q + LINE_W'(1);
                            k_q       <= K_LAST;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= addr_of(line_q + LINE_W'(1), K_LAST);
                            state_q   <= S_FETCH;
                        end else begin
                            done_q <= 1'b1;
                            // A start arriving on this very cycle counts as pending.
                            if (pend_q || I_frame_start) begin
                                pend_q    <= 1'b0;
                                bright_q  <= I_bright;
                                line_q    <= {LINE_W{1'b0}};
                                k_q       <= K_LAST;
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= addr_of({LINE_W{1'b0}}, K_LAST);
                                state_q   <= S_FETCH;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Free-running GCLK divider, held low with a cleared divider throughout BLANK.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            gclk_q <= 1'b0;
            gdiv_q <= {GDIV_W{1'b0}};
        end else if (blank_next_d) begin
            gclk_q <= 1'b0;
            gdiv_q <= {GDIV_W{1'b0}};
        end else if (gdiv_q == GDIV_LAST) begin
            gclk_q <= ~gclk_q;
            gdiv_q <= {GDIV_W{1'b0}};
        end else begin
            gdiv_q <= gdiv_q + GDIV_W'(1);
        end
    end

    assign O_rd_en      = rd_en_q;
    assign O_rd_addr    = rd_addr_q;
    assign O_busy       = busy_q;
    assign O_frame_done = done_q;
    assign DCLK         = dclk_q;
    assign SDI          = sdi_q;
    assign LE           = le_q;
    assign GCLK         = gclk_q;
    assign O_scan       = scan_q;

endmodule
